simplecpu_loader: RTL

Program-load initiator for the simplecpu RAM load port. It accepts a byte stream over a valid/ready handshake and drives the CPU's load port: one `load_ram` strobe per byte, addresses 0..DEPTH-1 in order. It holds the CPU in reset while loading and releases it only after a complete image has been written. It sits between a byte source (management SoC bridge or serial receiver) and `simplecpu`, and replaces direct logic-analyzer bit-banging of the load port.

---
 rtl/simplecpu_loader_pkg.sv | 16 +
 rtl/simplecpu_loader_if.sv | 25 ++
 rtl/simplecpu_loader.sv | 124 ++++++++++++
 3 files changed

// File: rtl/simplecpu_loader_pkg.sv
// Shared definitions for the simplecpu program loader: bus width defaults
// and the loader FSM state encoding.
package simplecpu_loader_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;
    localparam int HOLD_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/simplecpu_loader_if.sv
// Byte stream in (valid/ready) and CPU RAM load port out, bundled together.
// Stream: a byte transfers on a rising clock edge where in_valid and in_ready are both high.
interface simplecpu_loader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              load_ram;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;

    // Source / CPU side
    modport master (
        output in_valid, in_data,
        input  in_ready, load_ram, load_addr, load_data
    );

    // Loader side
    modport slave (
        input  in_valid, in_data,
        output in_ready, load_ram, load_addr, load_data
    );
endinterface

// File: rtl/simplecpu_loader.sv
// Program-load initiator: writes a 16-byte image into simplecpu RAM and holds
// the CPU in reset until a complete image has landed. All outputs registered.
module simplecpu_loader
    import simplecpu_loader_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic                 start,
    simplecpu_loader_if.slave    bus,
    output logic                 cpu_reset,
    output logic                 busy,
    output logic                 done,
    output state_t               dbg_state
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES);

    state_t              state_q, state_n;
    logic [ADDR_W-1:0]   addr_q, addr_n;
    logic [HOLD_W-1:0]   cnt_q, cnt_n;
    logic                loaded_q, loaded_n;
    logic                in_ready_q, in_ready_n;
    logic                load_ram_q, load_ram_n;
    logic [ADDR_W-1:0]   load_addr_q, load_addr_n;
    logic [DATA_W-1:0]   load_data_q, load_data_n;
    logic                cpu_reset_q, cpu_reset_n;
    logic                busy_q, busy_n;
    logic                done_q, done_n;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            loaded_q    <= 1'b0;
            in_ready_q  <= 1'b0;
            load_ram_q  <= 1'b0;
            load_addr_q <= '0;
            load_data_q <= '0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_n;
            addr_q      <= addr_n;
            cnt_q       <= cnt_n;
            loaded_q    <= loaded_n;
            in_ready_q  <= in_ready_n;
            load_ram_q  <= load_ram_n;
            load_addr_q <= load_addr_n;
            load_data_q <= load_data_n;
            cpu_reset_q <= cpu_reset_n;
            busy_q      <= busy_n;
            done_q      <= done_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        addr_n      = addr_q;
        cnt_n       = cnt_q;
        loaded_n    = loaded_q;
        load_addr_n = load_addr_q;
        load_data_n = load_data_q;
        done_n      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_RECV;
                    addr_n  = '0;
                end
            end
            ST_RECV: begin
                // in_ready is registered high for the whole RECV stay
                if (bus.in_valid && in_ready_q) begin
                    state_n     = ST_WRITE;
                    load_addr_n = addr_q;
                    load_data_n = bus.in_data;
                end
            end
            ST_WRITE: begin
                if (addr_q == LAST_ADDR) begin
                    state_n = ST_HOLD;
                    cnt_n   = HOLD_INIT;
                end else begin
                    state_n = ST_RECV;
                    addr_n  = addr_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q <= HOLD_W'(1)) begin
                    state_n  = ST_IDLE;
                    loaded_n = 1'b1;
                    done_n   = 1'b1;
                end else begin
                    cnt_n = cnt_q - 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Outputs are registered copies of what the next state implies
        in_ready_n  = (state_n == ST_RECV);
        load_ram_n  = (state_n == ST_WRITE);
        busy_n      = (state_n != ST_IDLE);
        cpu_reset_n = (state_n != ST_IDLE) || !loaded_n;
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.load_ram  = load_ram_q;
    assign bus.load_addr = load_addr_q;
    assign bus.load_data = load_data_q;
    assign cpu_reset     = cpu_reset_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign dbg_state     = state_q;

endmodule
